// File: rtl/axil_reg_pkg.sv
// rtl/axil_reg_pkg.sv - register map, response codes and select encoding for axil_reg_slave
package axil_reg_pkg;

  localparam logic [31:0] REG_ID       = 32'h0000_0000;
  localparam logic [31:0] REG_SCRATCH0 = 32'h0000_0010;
  localparam logic [31:0] REG_SCRATCH1 = 32'h0000_0014;
  localparam logic [31:0] REG_SCRATCH2 = 32'h0000_0018;
  localparam logic [31:0] REG_SCRATCH3 = 32'h0000_001C;
  localparam logic [31:0] REG_CTRL     = 32'h0000_0020;
  localparam logic [31:0] REG_STATUS   = 32'h0000_0024;
  localparam logic [31:0] REG_FLAGS    = 32'h0000_0028;
  localparam logic [31:0] REG_CYCLES   = 32'h0000_002C;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] ERR_PATTERN  = 32'hDEAD_BEEF;

  typedef enum logic [3:0] {
    SEL_ID,
    SEL_SCRATCH0,
    SEL_SCRATCH1,
    SEL_SCRATCH2,
    SEL_SCRATCH3,
    SEL_CTRL,
    SEL_STATUS,
    SEL_FLAGS,
    SEL_CYCLES,
    SEL_NONE
  } reg_sel_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axil_reg_decode.sv
// rtl/axil_reg_decode.sv - address to register select decode, shared by read and write paths
module axil_reg_decode
  import axil_reg_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic [ADDR_W-1:0] addr,
  output reg_sel_e          sel,
  output logic              valid
);

  logic [31:0] offset;

  // All map entries are word aligned, so a misaligned address simply falls to the default.
  always_comb begin
    offset = 32'(addr);
    case (offset)
      REG_ID:       sel = SEL_ID;
      REG_SCRATCH0: sel = SEL_SCRATCH0;
      REG_SCRATCH1: sel = SEL_SCRATCH1;
      REG_SCRATCH2: sel = SEL_SCRATCH2;
      REG_SCRATCH3: sel = SEL_SCRATCH3;
      REG_CTRL:     sel = SEL_CTRL;
      REG_STATUS:   sel = SEL_STATUS;
      REG_FLAGS:    sel = SEL_FLAGS;
      REG_CYCLES:   sel = SEL_CYCLES;
      default:      sel = SEL_NONE;
    endcase
    valid = (sel != SEL_NONE);
  end

endmodule

// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI-Lite register bank: ID, scratch, control, status, W1C flags, cycle counter
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] ID_VALUE = 32'h2025_0127,
  parameter int          NUM_EVT  = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [ADDR_W-1:0]  s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [ADDR_W-1:0]  s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [31:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic [31:0]        ctrl_out,
  input  logic [31:0]        status_in,
  input  logic [NUM_EVT-1:0] evt_in
);

  logic              aw_full, w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [31:0]       scratch [4];
  logic [31:0]       ctrl, cycles;
  logic [NUM_EVT-1:0] flags, flag_clr;

  logic              aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data, wr_mask, wr_bits;
  logic [3:0]        wr_strb;
  reg_sel_e          wr_sel, rd_sel;
  logic              wr_valid, rd_valid;
  logic [31:0]       rd_data, rd_flags;
  logic [1:0]        rd_resp;

  assign s_awready = !aw_full && !s_bvalid;
  assign s_wready  = !w_full && !s_bvalid;
  assign s_arready = !s_rvalid;
  assign ctrl_out  = ctrl;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // Commit on the edge where the second half arrives, so same-cycle AW+W gives bvalid one cycle later.
  assign commit  = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr = aw_full ? aw_addr_q : s_awaddr;
  assign wr_data = w_full ? w_data_q : s_wdata;
  assign wr_strb = w_full ? w_strb_q : s_wstrb;
  assign wr_mask = strb_mask(wr_strb);
  assign wr_bits = wr_data & wr_mask;
  assign wr_ok   = commit && wr_valid;

  axil_reg_decode #(.ADDR_W(ADDR_W)) u_wr_dec (.addr(wr_addr),  .sel(wr_sel), .valid(wr_valid));
  axil_reg_decode #(.ADDR_W(ADDR_W)) u_rd_dec (.addr(s_araddr), .sel(rd_sel), .valid(rd_valid));

  always_comb begin
    flag_clr = '0;
    if (wr_ok && wr_sel == SEL_FLAGS) flag_clr = wr_bits[NUM_EVT-1:0];
  end

  always_comb begin
    rd_flags = '0;
    rd_flags[NUM_EVT-1:0] = flags;
    rd_resp = rd_valid ? RESP_OKAY : RESP_SLVERR;
    case (rd_sel)
      SEL_ID:       rd_data = ID_VALUE;
      SEL_SCRATCH0: rd_data = scratch[0];
      SEL_SCRATCH1: rd_data = scratch[1];
      SEL_SCRATCH2: rd_data = scratch[2];
      SEL_SCRATCH3: rd_data = scratch[3];
      SEL_CTRL:     rd_data = ctrl;
      SEL_STATUS:   rd_data = status_in;
      SEL_FLAGS:    rd_data = rd_flags;
      SEL_CYCLES:   rd_data = cycles;
      default:      rd_data = ERR_PATTERN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
      ctrl      <= '0;
      cycles    <= '0;
      flags     <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_rvalid  <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rdata   <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      // Set wins: a pulse arriving with a W1C clear of the same bit keeps it set.
      flags  <= (flags & ~flag_clr) | evt_in;

      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= s_awaddr;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= s_wdata;
          w_strb_q <= s_wstrb;
        end
      end

      if (commit) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_valid ? RESP_OKAY : RESP_SLVERR;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end

      if (wr_ok) begin
        case (wr_sel)
          SEL_SCRATCH0: scratch[0] <= (scratch[0] & ~wr_mask) | wr_bits;
          SEL_SCRATCH1: scratch[1] <= (scratch[1] & ~wr_mask) | wr_bits;
          SEL_SCRATCH2: scratch[2] <= (scratch[2] & ~wr_mask) | wr_bits;
          SEL_SCRATCH3: scratch[3] <= (scratch[3] & ~wr_mask) | wr_bits;
          SEL_CTRL:     ctrl       <= (ctrl & ~wr_mask) | wr_bits;
          default: ;
        endcase
      end

      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_data;
        s_rresp  <= rd_resp;
      end else if (s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - self-checking bench for axil_reg_slave
module tb_axil_reg_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [14:0] s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] ctrl_out, status;
  logic [7:0]  evt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_reg_slave dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ctrl_out(ctrl_out), .status_in(status), .evt_in(evt)
  );

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] ctrl;
  } vec_t;
  vec_t vq[$];

  // Reference model state
  logic [31:0] m_scratch [4];
  logic [31:0] m_ctrl;
  logic [7:0]  m_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit wr, input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] r, input logic [31:0] rd, input logic [31:0] c);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd; v.ctrl = c;
    vq.push_back(v);
  endtask

  // Tasks start and end on a falling edge.
  task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [7:0] ev, output logic [1:0] resp);
    chk("aw_ready_idle", 32'(s_awready), 32'd1);
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    s_bready = 1'b1; evt = ev;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; evt = 8'h00;
    chk("bvalid_n1", 32'(s_bvalid), 32'd1);
    resp = s_bresp;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [14:0] a, output logic [1:0] resp, output logic [31:0] d);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    chk("rvalid_n1", 32'(s_rvalid), 32'd1);
    resp = s_rresp; d = s_rdata;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Word index of a mapped register (offset/4), or -1 for a decode error.
  function automatic int model_idx(input logic [14:0] a);
    if (a[1:0] != 2'b00) return -1;
    if (a == 15'h0) return 0;
    if (a >= 15'h10 && a <= 15'h2C) return int'(a) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  function automatic logic [14:0] rand_addr();
    logic [14:0] base;
    int k = $urandom_range(0, 11);
    case ($urandom_range(0, 8))
      0: base = 15'h00;  1: base = 15'h10;  2: base = 15'h14;
      3: base = 15'h18;  4: base = 15'h1C;  5: base = 15'h20;
      6: base = 15'h24;  7: base = 15'h28;  default: base = 15'h2C;
    endcase
    if (k <= 8) return base;
    if (k == 9) return 15'(4 * $urandom_range(12, 8191));
    if (k == 10) return 15'(4 * $urandom_range(1, 3));
    return base | 15'($urandom_range(1, 3));
  endfunction

  logic [1:0]  r;
  logic [31:0] d, c1, c2, exp_d;
  logic [1:0]  exp_r;
  int          idx;
  bit          stray;

  initial begin
    rstn = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    status = 32'h0; evt = 8'h00;

    add_vec(0, 15'h0000, 32'h0,          4'h0, 2'b00, 32'h2025_0127, 32'h0);
    add_vec(1, 15'h0020, 32'hA5A5_1234,  4'b0011, 2'b00, 32'h0,      32'h0000_1234);
    add_vec(0, 15'h0020, 32'h0,          4'h0, 2'b00, 32'h0000_1234, 32'h0000_1234);
    add_vec(1, 15'h0010, 32'h1122_3344,  4'hF, 2'b00, 32'h0,         32'h0000_1234);
    add_vec(1, 15'h0010, 32'hAABB_CCDD,  4'b0100, 2'b00, 32'h0,      32'h0000_1234);
    add_vec(0, 15'h0010, 32'h0,          4'h0, 2'b00, 32'h11BB_3344, 32'h0000_1234);
    add_vec(1, 15'h0000, 32'hFFFF_FFFF,  4'hF, 2'b00, 32'h0,         32'h0000_1234);
    add_vec(0, 15'h0000, 32'h0,          4'h0, 2'b00, 32'h2025_0127, 32'h0000_1234);
    add_vec(0, 15'h0100, 32'h0,          4'h0, 2'b10, 32'hDEAD_BEEF, 32'h0000_1234);
    add_vec(0, 15'h0012, 32'h0,          4'h0, 2'b10, 32'hDEAD_BEEF, 32'h0000_1234);
    add_vec(1, 15'h7FFC, 32'h1234_5678,  4'hF, 2'b10, 32'h0,         32'h0000_1234);
    add_vec(1, 15'h0022, 32'hFFFF_FFFF,  4'hF, 2'b10, 32'h0,         32'h0000_1234);
    add_vec(0, 15'h0010, 32'h0,          4'h0, 2'b00, 32'h11BB_3344, 32'h0000_1234);
    add_vec(0, 15'h001C, 32'h0,          4'h0, 2'b00, 32'h0,         32'h0000_1234);

    @(negedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 32'd1);
    chk("rst_wready",  32'(s_wready),  32'd1);
    chk("rst_arready", 32'(s_arready), 32'd1);
    chk("rst_bvalid",  32'(s_bvalid),  32'd0);
    chk("rst_rvalid",  32'(s_rvalid),  32'd0);
    chk("rst_rdata",   s_rdata,        32'h0);
    chk("rst_resp",    32'({s_bresp, s_rresp}), 32'h0);
    chk("rst_ctrl",    ctrl_out,       32'h0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vq[i]) begin
      if (vq[i].wr) begin
        do_write(vq[i].addr, vq[i].data, vq[i].strb, 8'h00, r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vq[i].resp));
      end else begin
        do_read(vq[i].addr, r, d);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vq[i].resp));
        chk($sformatf("vec%0d_rdata", i), d, vq[i].rdata);
      end
      chk($sformatf("vec%0d_ctrl", i), ctrl_out, vq[i].ctrl);
    end

    // Cycle counter: handshakes 10 cycles apart
    do_read(15'h002C, r, c1);
    repeat (8) @(negedge clk);
    do_read(15'h002C, r, c2);
    chk("cycles_delta", c2 - c1, 32'd10);

    // W one cycle ahead of AW, then B held off for 5 cycles
    s_bready = 1'b0;
    s_wdata = 32'h1357_9BDF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    chk("wfirst_wready", 32'(s_wready), 32'd0);
    chk("wfirst_bvalid", 32'(s_bvalid), 32'd0);
    chk("wfirst_awready", 32'(s_awready), 32'd1);
    s_awaddr = 15'h0014; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 32'(s_bvalid), 32'd1);
      chk("bp_readies", 32'({s_awready, s_wready}), 32'd0);
      chk("bp_bresp", 32'(s_bresp), 32'd0);
      @(negedge clk);
    end
    s_bready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'({s_bvalid, s_awready, s_wready}), 32'b011);
    do_write(15'h0018, 32'h2468_ACE0, 4'hF, 8'h00, r);
    chk("bp_next_bresp", 32'(r), 32'd0);
    do_read(15'h0014, r, d);
    chk("bp_scratch1", d, 32'h1357_9BDF);

    // FLAGS: set wins over a same-cycle clear
    evt = 8'h05;
    @(negedge clk);
    evt = 8'h00;
    do_write(15'h0028, 32'h1, 4'hF, 8'h01, r);
    do_read(15'h0028, r, d);
    chk("flags_setwins", d, 32'h05);
    do_write(15'h0028, 32'h1, 4'hF, 8'h00, r);
    do_read(15'h0028, r, d);
    chk("flags_clear", d, 32'h04);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4; i++) m_scratch[i] = '0;
    m_ctrl = '0; m_flags = '0;
    for (int n = 0; n < 200; n++) begin
      logic [14:0] a = rand_addr();
      idx = model_idx(a);
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] wd = $urandom;
        logic [3:0]  ws = 4'($urandom_range(0, 15));
        do_write(a, wd, ws, 8'h00, r);
        chk("rnd_bresp", 32'(r), (idx < 0) ? 32'd2 : 32'd0);
        if (idx >= 4 && idx <= 7) m_scratch[idx-4] = merge(m_scratch[idx-4], wd, ws);
        if (idx == 8) m_ctrl = merge(m_ctrl, wd, ws);
        if (idx == 10) m_flags = m_flags & ~merge(32'h0, wd, ws);
        chk("rnd_ctrl", ctrl_out, m_ctrl);
      end else begin
        status = $urandom;
        exp_r = (idx < 0) ? 2'b10 : 2'b00;
        case (idx)
          -1:      exp_d = 32'hDEAD_BEEF;
          0:       exp_d = 32'h2025_0127;
          8:       exp_d = m_ctrl;
          9:       exp_d = status;
          10:      exp_d = 32'(m_flags);
          default: exp_d = (idx >= 4 && idx <= 7) ? m_scratch[idx-4] : 32'h0;
        endcase
        do_read(a, r, d);
        chk("rnd_rresp", 32'(r), 32'(exp_r));
        if (idx != 11) chk($sformatf("rnd_rdata@%h", a), d, exp_d);
      end
    end

    // Reset while R is pending and an AW is buffered
    do_write(15'h0020, 32'hCAFE_F00D, 4'hF, 8'h00, r);
    chk("pre_rst_ctrl", ctrl_out, 32'hCAFE_F00D);
    s_rready = 1'b0;
    s_araddr = 15'h0000; s_arvalid = 1'b1;
    s_awaddr = 15'h0020; s_awvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0; s_awvalid = 1'b0;
    chk("pend_rvalid", 32'(s_rvalid), 32'd1);
    chk("pend_awready", 32'(s_awready), 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("async_rvalid", 32'(s_rvalid), 32'd0);
    chk("async_readies", 32'({s_awready, s_wready, s_arready}), 32'b111);
    chk("async_ctrl", ctrl_out, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    s_bready = 1'b1;
    s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      if (s_bvalid) stray = 1'b1;
      @(negedge clk);
    end
    chk("dropped_aw_no_bvalid", 32'(stray), 32'd0);
    chk("dropped_aw_ctrl", ctrl_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
AXI-Lite slave register bank that answers the USB command handler's REG_WRITE and REG_READ accesses.
- Provides an ID word, scratch registers, a control word, a status word, W1C event flags and a free-running cycle counter.
- Sits between the command handler's AXI-Lite master port and the design logic it controls or observes.
- Handles independent AW/W arrival and backpressure on B/R.

Parameters:
ADDR_W, 15, AXI-Lite address width; matches the command handler's awaddr/araddr.
ID_VALUE, 32'h20250127, constant returned at offset 0x0000.
NUM_EVT, 8, number of event inputs and W1C flag bits (1..32).

Ports:
clk  in  1  single clock
rstn  in  1  async active-low reset
s_awaddr  in  ADDR_W  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_W  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read response valid
s_rready  in  1  read response ready
ctrl_out  out  32  CTRL register contents
status_in  in  32  live status word, sampled on read
evt_in  in  NUM_EVT  single-cycle event pulses

Behaviour:
- Reset: rstn low asynchronously clears all state.
  - s_bvalid, s_rvalid, ctrl_out, flags, counter and scratch reset to 0.
  - s_bresp, s_rresp and s_rdata reset to 0.
  - s_awready, s_wready and s_arready are 1 in reset/idle.
  - Reset mid-transaction drops any buffered AW/W or pending B/R with no response.
- Register map (byte offsets):
  - 0x0000 ID: RO, returns ID_VALUE.
  - 0x0010-0x001C SCRATCH0-3: RW, honours wstrb.
  - 0x0020 CTRL: RW, honours wstrb, drives ctrl_out.
  - 0x0024 STATUS: RO, returns status_in.
  - 0x0028 FLAGS: W1C, bits [NUM_EVT-1:0]; upper bits read 0.
  - 0x002C CYCLES: RO, 32-bit counter, +1 every clk, wraps 0xFFFFFFFF->0.
- Error responses:
  - Decode error: address unmapped, or addr[1:0]!=0, gives resp 2'b10 (SLVERR).
  - Read SLVERR returns rdata 0xDEADBEEF.
  - Write SLVERR changes no state.
  - Writes to RO registers: OKAY, ignored.
- Write channel:
  - AW and W are captured independently into one-entry buffers.
  - s_awready = !aw_buf_full && !s_bvalid; s_wready = !w_buf_full && !s_bvalid.
  - Master may present AW and W for a single cycle only, so idle ready must be high combinationally.
  - The cycle after both buffers are full, the write commits, buffers clear, s_bvalid=1 with s_bresp.
  - Latency: AW+W same-cycle handshake at cycle N gives commit and bvalid at N+1.
  - s_bvalid holds until s_bready; no new AW/W is accepted while bvalid is high.
- Read channel:
  - s_arready = !s_rvalid.
  - On handshake at cycle N, rdata/rresp are registered and s_rvalid=1 at N+1, held stable until s_rready.
  - STATUS and CYCLES are sampled at cycle N.
- Simultaneous events:
  - A read sampled in the same cycle a write commits to that register returns the pre-write value.
  - FLAGS: a new evt_in pulse in the same cycle as a W1C clear of that bit leaves the bit set (set wins).
  - The read and write channels are fully independent; both may complete in the same cycle.

Decomposition:
- Package axil_reg_pkg holds:
  - register offset constants (REG_ID, REG_SCRATCH0..3, REG_CTRL, REG_STATUS, REG_FLAGS, REG_CYCLES);
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the DEADBEEF error pattern.
- One sub-module, axil_reg_decode: combinational address-to-select/valid decode, shared by the read and write paths.

Test Plan:
- After reset, read 0x0000 with rready=1 -> rvalid one cycle after AR handshake, rdata=0x20250127, rresp=0; 0x002C read twice 10 cycles apart differs by 10.
- Write 0x0020 data 0xA5A5_1234 with wstrb=4'b0011 and single-cycle AW/W -> bvalid at N+1 with bresp=0; ctrl_out=0x0000_1234; readback matches.
- W one cycle before AW, bready held low 5 cycles -> awready/wready stay 0 while bvalid=1; bvalid drops on bready; next write accepted the following cycle.
- Pulse evt_in=8'h05, then write 0x0028 with 0x01 in the same cycle as evt_in[0] pulses again -> FLAGS reads 0x05. Next write 0x01 with no event -> FLAGS=0x04.
- Read 0x0100 and 0x0012, write 0x7FFC -> rresp=2'b10 with rdata 0xDEADBEEF; bresp=2'b10; no register changes.
- Assert rstn low while rvalid=1 and while an AW is buffered -> rvalid=0 and ready outputs=1 immediately; CTRL=0 and the dropped write never commits.
